// File: rtl/rpspmc_axis_pkg.sv
// Shared definitions for the RPSPMC AXI-stream processing blocks.
package rpspmc_axis_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MAX_SHIFT  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } dec_state_e;

endpackage

// File: rtl/axis_dec_round.sv
// Rounded mean of a block sum: (acc + 2^(shift-1)) >>> shift, round-half-up.
module axis_dec_round #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_SHIFT  = 8
) (
  input  logic [DATA_WIDTH+MAX_SHIFT-1:0] acc_i,
  input  logic [$clog2(MAX_SHIFT+1)-1:0]  shift_i,
  output logic [DATA_WIDTH-1:0]           result_o
);

  localparam int AW = DATA_WIDTH + MAX_SHIFT;
  localparam int SW = $clog2(MAX_SHIFT + 1);

  logic        [AW-1:0] half;
  logic signed [AW-1:0] rounded;

  // The extra MAX_SHIFT bits of headroom absorb the rounding term, so
  // a full-scale block lands exactly on full-scale after the shift.
  always_comb begin
    half = '0;
    if (shift_i != '0) begin
      half = AW'(1) << (shift_i - SW'(1));
    end
    rounded  = $signed(acc_i + half);
    result_o = DATA_WIDTH'(rounded >>> shift_i);
  end

endmodule

// File: rtl/axis_decimator_avg.sv
// Block-averaging decimator: emits the rounded mean of every 2^cur_shift
// accepted samples as a single-cycle beat. No backpressure.
module axis_decimator_avg
  import rpspmc_axis_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_SHIFT  = DEF_MAX_SHIFT
) (
  input  logic                           a_clk,
  input  logic                           a_reset,
  input  logic [DATA_WIDTH-1:0]          S_AXIS_tdata,
  input  logic                           S_AXIS_tvalid,
  input  logic                           enable,
  input  logic [$clog2(MAX_SHIFT+1)-1:0] dec_shift,
  output logic [DATA_WIDTH-1:0]          M_AXIS_tdata,
  output logic                           M_AXIS_tvalid,
  output logic [DATA_WIDTH-1:0]          monitor,
  output logic [MAX_SHIFT:0]             count,
  output dec_state_e                     dbg_state
);

  // Handshake: a sample is taken on every cycle S_AXIS_tvalid is high while
  // the block is active; M_AXIS_tvalid is a one-cycle pulse, there is no ready.

  localparam int AW = DATA_WIDTH + MAX_SHIFT;
  localparam int SW = $clog2(MAX_SHIFT + 1);
  localparam int CW = MAX_SHIFT + 1;

  dec_state_e            state_q, state_d;
  logic [SW-1:0]         cur_shift_q, cur_shift_d;
  logic [AW-1:0]         acc_q, acc_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;

  logic [SW-1:0]         clamp_shift;
  logic [SW-1:0]         eff_shift;
  logic [AW-1:0]         sample_ext;
  logic [AW-1:0]         acc_sum;
  logic [CW-1:0]         block_len;
  logic                  accept;
  logic                  done;
  logic [DATA_WIDTH-1:0] rounded;

  always_ff @(posedge a_clk or posedge a_reset) begin
    if (a_reset) begin
      state_q     <= IDLE;
      cur_shift_q <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_shift_q <= cur_shift_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
    end
  end

  // In the IDLE->ACCUM cycle the incoming sample already belongs to a block
  // whose length comes straight from dec_shift, before it is latched.
  always_comb begin
    clamp_shift = (dec_shift > SW'(MAX_SHIFT)) ? SW'(MAX_SHIFT) : dec_shift;
    eff_shift   = (state_q == IDLE) ? clamp_shift : cur_shift_q;
    sample_ext  = {{MAX_SHIFT{S_AXIS_tdata[DATA_WIDTH-1]}}, S_AXIS_tdata};
    acc_sum     = acc_q + sample_ext;
    block_len   = CW'(1) << eff_shift;
    accept      = ((state_q == ACCUM) || enable) && S_AXIS_tvalid;
    done        = accept && ((count_q + CW'(1)) == block_len);
  end

  axis_dec_round #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_SHIFT  (MAX_SHIFT)
  ) u_round (
    .acc_i    (acc_sum),
    .shift_i  (eff_shift),
    .result_o (rounded)
  );

  always_comb begin
    state_d     = enable ? ACCUM : IDLE;
    cur_shift_d = cur_shift_q;
    acc_d       = acc_q;
    count_d     = count_q;
    tdata_d     = tdata_q;
    tvalid_d    = 1'b0;

    if ((state_q == IDLE) && enable) begin
      cur_shift_d = clamp_shift;
    end

    // A completing sample wins over enable low: the block is still emitted.
    if (done) begin
      tvalid_d    = 1'b1;
      tdata_d     = rounded;
      acc_d       = '0;
      count_d     = '0;
      cur_shift_d = clamp_shift;
    end else if (!enable) begin
      acc_d   = '0;
      count_d = '0;
    end else if (accept) begin
      acc_d   = acc_sum;
      count_d = count_q + CW'(1);
    end
  end

  assign M_AXIS_tdata  = tdata_q;
  assign M_AXIS_tvalid = tvalid_q;
  assign monitor       = tdata_q;
  assign count         = count_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_axis_decimator_avg.sv
// Bench for axis_decimator_avg: directed scenarios plus random traffic
// against a queue-based block-mean model, checked every cycle.
module tb_axis_decimator_avg;
  import rpspmc_axis_pkg::*;

  localparam int DW = 32;
  localparam int MS = 8;
  localparam int SW = 4;
  localparam int CW = 9;

  logic          a_clk = 1'b0;
  logic          a_reset = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          enable = 1'b0;
  logic [SW-1:0] dec_shift = '0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic [DW-1:0] monitor;
  logic [CW-1:0] count;
  dec_state_e    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 a_clk = ~a_clk;

  axis_decimator_avg #(.DATA_WIDTH(DW), .MAX_SHIFT(MS)) dut (
    .a_clk         (a_clk),
    .a_reset       (a_reset),
    .S_AXIS_tdata  (s_tdata),
    .S_AXIS_tvalid (s_tvalid),
    .enable        (enable),
    .dec_shift     (dec_shift),
    .M_AXIS_tdata  (m_tdata),
    .M_AXIS_tvalid (m_tvalid),
    .monitor       (monitor),
    .count         (count),
    .dbg_state     (dbg_state)
  );

  // ---------------- reference model ----------------
  longint        blk[$];
  int            cur_n = 1;
  bit            m_accum = 1'b0;
  bit            exp_valid = 1'b0;
  logic [DW-1:0] exp_data = '0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mq[$];
  logic [DW-1:0] dq[$];
  longint        m_sum;

  function automatic int clamp_sh(input logic [SW-1:0] s);
    return (int'(s) > MS) ? MS : int'(s);
  endfunction

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Mean rounded half-up: floor(sum/N + 1/2) = floor((2*sum + N) / (2*N)).
  always @(posedge a_clk or posedge a_reset) begin
    if (a_reset) begin
      blk.delete();
      m_accum   = 1'b0;
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_q.delete();
    end else begin
      exp_valid = 1'b0;
      if (!m_accum && enable) cur_n = 1 << clamp_sh(dec_shift);
      if ((m_accum || enable) && s_tvalid) begin
        blk.push_back(longint'($signed(s_tdata)));
        if (blk.size() == cur_n) begin
          m_sum = 0;
          foreach (blk[i]) m_sum = m_sum + blk[i];
          exp_data  = DW'(floor_div(2 * m_sum + longint'(cur_n), 2 * longint'(cur_n)));
          exp_valid = 1'b1;
          exp_q.push_back(exp_data);
          mq.push_back(exp_data);
          blk.delete();
          cur_n = 1 << clamp_sh(dec_shift);
        end
      end
      if (!enable) blk.delete();
      m_accum = enable;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge a_clk) begin
    chk("tvalid", 64'(m_tvalid), 64'(exp_valid));
    chk("tdata", 64'(m_tdata), 64'(exp_data));
    chk("monitor", 64'(monitor), 64'(exp_data));
    chk("count", 64'(count), 64'(blk.size()));
    chk("state", 64'(dbg_state), 64'(m_accum));
    if (m_tvalid) begin
      dq.push_back(m_tdata);
      if (exp_q.size() == 0) begin
        chk("beat_expected", 64'(1), 64'(0));
      end else begin
        chk("beat_data", 64'(m_tdata), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic check_beats(input string nm, input int n,
                             input logic [DW-1:0] r0, input logic [DW-1:0] r1,
                             input logic [DW-1:0] r2, input logic [DW-1:0] r3);
    logic [DW-1:0] r[4];
    r = '{r0, r1, r2, r3};
    chk({nm, "_dut_beats"}, 64'(dq.size()), 64'(n));
    chk({nm, "_model_beats"}, 64'(mq.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < dq.size()) chk({nm, "_dut_value"}, 64'(dq[i]), 64'(r[i]));
      if (i < mq.size()) chk({nm, "_model_value"}, 64'(mq[i]), 64'(r[i]));
    end
    dq.delete();
    mq.delete();
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit en, input bit vld, input logic [DW-1:0] d,
                       input logic [SW-1:0] sh);
    @(posedge a_clk);
    #2;
    enable    = en;
    s_tvalid  = vld;
    s_tdata   = d;
    dec_shift = sh;
  endtask

  task automatic drop_enable(input logic [SW-1:0] sh);
    drive(1'b0, 1'b0, '0, sh);
    drive(1'b0, 1'b0, '0, sh);
  endtask

  task automatic settle(input logic [SW-1:0] sh);
    drive(enable, 1'b0, '0, sh);
    drive(enable, 1'b0, '0, sh);
  endtask

  // ---------------- stimulus ----------------
  logic [SW-1:0] rsh;

  initial begin
    #1 a_reset = 1'b1;
    #1;
    chk("rst_tdata", 64'(m_tdata), 64'(0));
    chk("rst_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    repeat (3) @(posedge a_clk);
    #2 a_reset = 1'b0;

    // Continuous 1..8 in blocks of 4, enable raised with the first sample.
    for (int i = 1; i <= 8; i++) drive(1'b1, 1'b1, DW'(i), 4'd2);
    settle(4'd2);
    check_beats("avg4", 2, 32'd3, 32'd7, '0, '0);

    drop_enable(4'd3);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 32'h8000_0000, 4'd3);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 32'h7fff_ffff, 4'd3);
    settle(4'd3);
    check_beats("fullscale", 2, 32'h8000_0000, 32'h7fff_ffff, '0, '0);

    drop_enable(4'd1);
    drive(1'b1, 1'b1, -32'sd3, 4'd1);
    drive(1'b1, 1'b0, '0, 4'd1);
    drive(1'b1, 1'b1, -32'sd4, 4'd1);
    drive(1'b1, 1'b0, '0, 4'd1);
    settle(4'd1);
    check_beats("halfup_neg", 1, -32'sd3, '0, '0, '0);

    // dec_shift drops to 0 mid-block; takes effect at the boundary.
    drop_enable(4'd2);
    drive(1'b1, 1'b1, 32'd4, 4'd2);
    drive(1'b1, 1'b1, 32'd8, 4'd2);
    drive(1'b1, 1'b1, 32'd12, 4'd0);
    drive(1'b1, 1'b1, 32'd16, 4'd0);
    drive(1'b1, 1'b1, 32'd5, 4'd0);
    drive(1'b1, 1'b1, -32'sd6, 4'd0);
    drive(1'b1, 1'b1, 32'd7, 4'd0);
    settle(4'd0);
    check_beats("shift_change", 4, 32'd10, 32'd5, -32'sd6, 32'd7);

    drop_enable(4'd2);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 32'd1, 4'd2);
    drop_enable(4'd2);
    chk("partial_count", 64'(count), 64'(0));
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 32'd10, 4'd2);
    settle(4'd2);
    chk("reenable_count", 64'(count), 64'(0));
    check_beats("reenable", 1, 32'd10, '0, '0, '0);

    // Asynchronous reset in the middle of a block.
    drop_enable(4'd2);
    drive(1'b1, 1'b1, 32'd5, 4'd2);
    drive(1'b1, 1'b1, 32'd5, 4'd2);
    @(posedge a_clk);
    #3;
    s_tvalid = 1'b0;
    a_reset  = 1'b1;
    #1;
    chk("midrst_tdata", 64'(m_tdata), 64'(0));
    chk("midrst_monitor", 64'(monitor), 64'(0));
    chk("midrst_tvalid", 64'(m_tvalid), 64'(0));
    chk("midrst_count", 64'(count), 64'(0));
    @(posedge a_clk);
    #2 a_reset = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 32'd9, 4'd2);
    settle(4'd2);
    check_beats("post_reset", 1, 32'd9, '0, '0, '0);

    // dec_shift above MAX_SHIFT clamps to 256-sample blocks; mean 7.5 -> 8.
    drop_enable(4'd15);
    for (int i = 0; i < 256; i++) drive(1'b1, 1'b1, (i == 0) ? 32'd135 : 32'd7, 4'd15);
    settle(4'd15);
    check_beats("clamp256", 1, 32'd8, '0, '0, '0);

    rsh = 4'd1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 63) == 0)
        rsh = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(9, 15)) : SW'($urandom_range(0, 4));
      drive($urandom_range(0, 31) != 0, $urandom_range(0, 3) != 0, DW'($urandom()), rsh);
    end
    settle(rsh);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
